dct_operand_stager: RTL and testbench

- Upstream feeder for the 8-input carry-save adder (csa_eight) in the hierarchical DCT datapath.
- Accepts one unsigned 8-bit pixel per cycle over a valid/ready stream and level-shifts it by -128.
- Applies per-tap sign conditioning (ones' complement plus a correction constant) and collects eight values into a ping-pong row buffer.
- Presents a registered 8-operand row, constant and approx_en on a valid/ready output that connects directly to csa_eight's a..h, constant and approx_en inputs.

---
 rtl/dct_pkg.sv | 29 ++
 rtl/dct_operand_stager_if.sv | 38 +++
 rtl/dct_operand_bank.sv | 85 ++++++++
 rtl/dct_operand_stager.sv | 119 +++++++++++
 tb/tb_dct_operand_stager.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT operand stager and its row banks.
package dct_pkg;

    localparam int SIZE        = 8;
    localparam int LEVEL_SHIFT = 128;
    localparam int N_TAPS      = 8;
    localparam int CNT_W       = $clog2(N_TAPS);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // ops[0] feeds csa_eight input a, ops[7] feeds h.
    typedef struct packed {
        logic [N_TAPS-1:0][SIZE-1:0] ops;
        logic [SIZE-1:0]             constant;
        logic                        approx;
    } row_t;

    function automatic logic [SIZE-1:0] popcount(input logic [N_TAPS-1:0] m);
        logic [SIZE-1:0] n;
        n = '0;
        for (int i = 0; i < N_TAPS; i++) n = n + SIZE'(m[i]);
        return n;
    endfunction

endpackage

// File: rtl/dct_operand_stager_if.sv
// Pixel-in / row-out stream bundle of the stager; in_flush exists only when
// DCT_STAGER_FLUSH_EN is defined.
interface dct_operand_stager_if;
    import dct_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     in_pixel;
    logic [N_TAPS-1:0]   in_sign_mask;
    logic                in_approx;
`ifdef DCT_STAGER_FLUSH_EN
    logic                in_flush;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [SIZE-1:0]     a, b, c, d, e, f, g, h;
    logic [SIZE-1:0]     constant;
    logic                approx_en;

    modport master (
        output in_valid, in_pixel, in_sign_mask, in_approx,
`ifdef DCT_STAGER_FLUSH_EN
        output in_flush,
`endif
        output out_ready,
        input  in_ready, out_valid, a, b, c, d, e, f, g, h, constant, approx_en
    );

    modport slave (
        input  in_valid, in_pixel, in_sign_mask, in_approx,
`ifdef DCT_STAGER_FLUSH_EN
        input  in_flush,
`endif
        input  out_ready,
        output in_ready, out_valid, a, b, c, d, e, f, g, h, constant, approx_en
    );

endinterface

// File: rtl/dct_operand_bank.sv
// One row bank: EMPTY/FILLING/FULL state, write-time sign conditioning and the
// popcount correction constant. Padding port exists with DCT_STAGER_FLUSH_EN.
module dct_operand_bank
    import dct_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [CNT_W-1:0]   wr_idx_i,
    input  logic [SIZE-1:0]    wr_x_i,
    input  logic [N_TAPS-1:0]  mask_i,
    input  logic               approx_i,
`ifdef DCT_STAGER_FLUSH_EN
    input  logic               pad_en_i,
    input  logic [CNT_W-1:0]   pad_from_i,
`endif
    input  logic               drain_i,
    output bank_state_t        state_o,
    output logic               full_o,
    output row_t               row_o
);

    bank_state_t       state_q, state_d;
    row_t              row_q;
    logic [N_TAPS-1:0] mask_q;
    logic [N_TAPS-1:0] mask_eff;
    logic              complete;

    // Element 0 carries the row's mask, so it must be conditioned with the live input.
    assign mask_eff = (wr_idx_i == '0) ? mask_i : mask_q;

`ifdef DCT_STAGER_FLUSH_EN
    assign complete = (wr_en_i && (wr_idx_i == CNT_W'(N_TAPS-1))) || pad_en_i;
`else
    assign complete = wr_en_i && (wr_idx_i == CNT_W'(N_TAPS-1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (wr_en_i)  state_d = FILLING;
            FILLING: if (complete) state_d = FULL;
            FULL:    if (drain_i)  state_d = EMPTY;
            default:               state_d = EMPTY;
        endcase
    end

    always_comb begin
        state_o = state_q;
        full_o  = (state_q == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            mask_q <= '0;
        end else begin
            if (wr_en_i) begin
                row_q.ops[wr_idx_i] <= mask_eff[wr_idx_i] ? ~wr_x_i : wr_x_i;
                if (wr_idx_i == '0) begin
                    mask_q         <= mask_i;
                    row_q.constant <= popcount(mask_i);
                    row_q.approx   <= approx_i;
                end
            end
`ifdef DCT_STAGER_FLUSH_EN
            // Pad taps are x = 0: ~0 = -1 on negated taps cancels their +1 in constant.
            if (pad_en_i) begin
                for (int i = 0; i < N_TAPS; i++) begin
                    if (CNT_W'(i) >= pad_from_i)
                        row_q.ops[i] <= mask_q[i] ? {SIZE{1'b1}} : {SIZE{1'b0}};
                end
            end
`endif
        end
    end

    assign row_o = row_q;

endmodule

// File: rtl/dct_operand_stager.sv
// Level-shifts pixels, conditions them per tap and ping-pongs rows into two banks
// feeding csa_eight. Optional row flush/padding with DCT_STAGER_FLUSH_EN.
module dct_operand_stager
    import dct_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    dct_operand_stager_if.slave   bus,
    output bank_state_t           dbg_bank0_state_o,
    output bank_state_t           dbg_bank1_state_o
);

    // Handshake: a beat transfers on a rising edge where valid && ready; valid never
    // waits on ready, and the producer holds its data while valid && !ready.

    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bank_state_t      st_s  [2];
    row_t             row_s [2];
    logic             full_s[2];
    logic [SIZE-1:0]  x;
    logic             wr_full;
    logic             accept;
    logic             drain;
    row_t             rd_row;

    assign x       = bus.in_pixel - SIZE'(LEVEL_SHIFT);
    assign wr_full = full_s[wr_ptr_q];
    assign accept  = bus.in_valid && bus.in_ready;
    assign drain   = bus.out_valid && bus.out_ready;

`ifdef DCT_STAGER_FLUSH_EN
    logic flush_pend_q, flush_pend_d;

    // Flush is acted on one cycle later so a coincident pixel lands before padding.
    assign flush_pend_d = bus.in_flush && !flush_pend_q
                       && ((st_s[wr_ptr_q] == FILLING) || accept)
                       && !(accept && (cnt_q == CNT_W'(N_TAPS-1)));
    assign bus.in_ready = !wr_full && !flush_pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flush_pend_q <= 1'b0;
        else     flush_pend_q <= flush_pend_d;
    end
`else
    assign bus.in_ready = !wr_full;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            if (cnt_q == CNT_W'(N_TAPS-1)) begin
                cnt_d    = '0;
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`ifdef DCT_STAGER_FLUSH_EN
        if (flush_pend_q) begin
            cnt_d    = '0;
            wr_ptr_d = ~wr_ptr_q;
        end
`endif
        if (drain) rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        dct_operand_bank u_bank (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (accept && (wr_ptr_q == 1'(gi))),
            .wr_idx_i   (cnt_q),
            .wr_x_i     (x),
            .mask_i     (bus.in_sign_mask),
            .approx_i   (bus.in_approx),
`ifdef DCT_STAGER_FLUSH_EN
            .pad_en_i   (flush_pend_q && (wr_ptr_q == 1'(gi))),
            .pad_from_i (cnt_q),
`endif
            .drain_i    (drain && (rd_ptr_q == 1'(gi))),
            .state_o    (st_s[gi]),
            .full_o     (full_s[gi]),
            .row_o      (row_s[gi])
        );
    end

    assign rd_row        = rd_ptr_q ? row_s[1] : row_s[0];
    assign bus.out_valid = full_s[rd_ptr_q];
    assign bus.a         = rd_row.ops[0];
    assign bus.b         = rd_row.ops[1];
    assign bus.c         = rd_row.ops[2];
    assign bus.d         = rd_row.ops[3];
    assign bus.e         = rd_row.ops[4];
    assign bus.f         = rd_row.ops[5];
    assign bus.g         = rd_row.ops[6];
    assign bus.h         = rd_row.ops[7];
    assign bus.constant  = rd_row.constant;
    assign bus.approx_en = rd_row.approx;

    assign dbg_bank0_state_o = st_s[0];
    assign dbg_bank1_state_o = st_s[1];

endmodule

// File: tb/tb_dct_operand_stager.sv
// Directed bench for dct_operand_stager: a negedge monitor models accepted pixels
// into an expected-row queue and checks every drained row against it.
module tb_dct_operand_stager;
    import dct_pkg::*;

    localparam int W = 73;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bank_state_t dbg0, dbg1;
    int          checks = 0;
    int          failures = 0;

    logic [W-1:0] exp_q[$];

    dct_operand_stager_if bus();

    dct_operand_stager dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .dbg_bank0_state_o (dbg0),
        .dbg_bank1_state_o (dbg1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] obs_row();
        return {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a,
                bus.constant, bus.approx_en};
    endfunction

    function automatic int csa_sum();
        int s;
        s = int'($signed(bus.a)) + int'($signed(bus.b)) + int'($signed(bus.c))
          + int'($signed(bus.d)) + int'($signed(bus.e)) + int'($signed(bus.f))
          + int'($signed(bus.g)) + int'($signed(bus.h)) + int'(bus.constant);
        return s;
    endfunction

    // ---------------- scoreboard model / monitor ----------------
    logic [7:0]   m_ops[8];
    int           m_cnt = 0;
    logic [7:0]   m_mask;
    logic         m_apx;
    logic         hold_prev = 1'b0;
    logic [W-1:0] hold_row;

    task automatic push_model_row();
        logic [W-1:0] v;
        v      = '0;
        v[0]   = m_apx;
        v[8:1] = 8'($countones(m_mask));
        for (int i = 0; i < 8; i++) v[9 + 8*i +: 8] = m_ops[i];
        exp_q.push_back(v);
        m_cnt = 0;
    endtask

    always @(negedge clk) begin
        logic [7:0] xs;
        if (rst) begin
            m_cnt     = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", W'(bus.out_valid), W'(1));
                chk("hold_row", obs_row(), hold_row);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL row_unexpected observed=%0h expected=none", obs_row());
                end else begin
                    chk("row", obs_row(), exp_q.pop_front());
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_row  = obs_row();
            if (bus.in_valid && bus.in_ready) begin
                if (m_cnt == 0) begin
                    m_mask = bus.in_sign_mask;
                    m_apx  = bus.in_approx;
                end
                xs = bus.in_pixel - 8'd128;
                m_ops[m_cnt] = m_mask[m_cnt] ? ~xs : xs;
                m_cnt++;
                if (m_cnt == 8) push_model_row();
            end
`ifdef DCT_STAGER_FLUSH_EN
            if (bus.in_flush && m_cnt > 0) begin
                for (int i = m_cnt; i < 8; i++) m_ops[i] = m_mask[i] ? 8'hFF : 8'h00;
                push_model_row();
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_px(input logic [7:0] p);
        logic took;
        int   n;
        bus.in_pixel = p;
        bus.in_valid = 1'b1;
        took = 1'b0;
        n = 0;
        while (!took && n < 40) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=stalled expected=accepted");
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_valid", W'(bus.out_valid), W'(1));
    endtask

    task automatic chk_ops(input string tag, input logic [7:0] e[8], input logic [7:0] k,
                           input logic apx);
        logic [W-1:0] v;
        v      = '0;
        v[0]   = apx;
        v[8:1] = k;
        for (int i = 0; i < 8; i++) v[9 + 8*i +: 8] = e[i];
        chk(tag, obs_row(), v);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] t1_px [8] = '{8'd255, 8'd188, 8'd173, 8'd163, 8'd228, 8'd248, 8'd255, 8'd218};
    logic [7:0] t1_exp[8] = '{8'd127, 8'd60, 8'd45, 8'd35, 8'd100, 8'd120, 8'd127, 8'd90};
    logic [7:0] t2_exp[8] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};

    initial begin
        int acc, took, stalls, pops, bad_gap, last_pop, n;
        bus.in_valid     = 1'b0;
        bus.in_pixel     = '0;
        bus.in_sign_mask = '0;
        bus.in_approx    = 1'b0;
        bus.out_ready    = 1'b1;
`ifdef DCT_STAGER_FLUSH_EN
        bus.in_flush     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_row", obs_row(), W'(0));
        chk("rst_banks", W'({dbg0, dbg1}), W'({EMPTY, EMPTY}));
        @(posedge clk);
        #1;
        chk("rst_in_ready", W'(bus.in_ready), W'(1));

        // test 1: mask 0, latency and literal operands
        for (int i = 0; i < 8; i++) begin
            send_px(t1_px[i]);
            if (i == 6) chk("t1_not_yet_valid", W'(bus.out_valid), W'(0));
        end
        bus.in_valid = 1'b0;
        chk("t1_latency", W'(bus.out_valid), W'(1));
        chk_ops("t1_ops", t1_exp, 8'd0, 1'b0);
        chk("t1_sum", W'(csa_sum()), W'(704));
        repeat (3) @(posedge clk);
        #1;

        // test 2: all -128 negated
        bus.in_sign_mask = 8'hFF;
        bus.in_approx    = 1'b1;
        for (int i = 0; i < 8; i++) send_px(8'd0);
        bus.in_valid = 1'b0;
        chk("t2_latency", W'(bus.out_valid), W'(1));
        chk_ops("t2_ops", t2_exp, 8'd8, 1'b1);
        chk("t2_sum", W'(csa_sum()), W'(1024));
        repeat (3) @(posedge clk);
        #1;

        // test 3: backpressure fills both banks
        bus.out_ready    = 1'b0;
        bus.in_approx    = 1'b0;
        bus.in_sign_mask = 8'($urandom_range(0, 255));
        bus.in_pixel     = 8'($urandom_range(0, 255));
        bus.in_valid     = 1'b1;
        acc = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            took = int'(bus.in_ready);
            @(posedge clk);
            #1;
            if (took != 0) begin
                acc++;
                bus.in_pixel = 8'($urandom_range(0, 255));
                if (acc % 8 == 0) bus.in_sign_mask = 8'($urandom_range(0, 255));
                bus.in_approx = 1'($urandom_range(0, 1));
            end
        end
        chk("t3_accepted", W'(acc), W'(16));
        chk("t3_ready_low", W'(bus.in_ready), W'(0));
        chk("t3_banks_full", W'({dbg0, dbg1}), W'({FULL, FULL}));
        bus.out_ready = 1'b1;
        chk("t3_ready_still_low", W'(bus.in_ready), W'(0));
        @(posedge clk);
        #1;
        chk("t3_ready_recover", W'(bus.in_ready), W'(1));
        n = 0;
        while (acc < 24 && n < 60) begin
            @(negedge clk);
            took = int'(bus.in_ready);
            @(posedge clk);
            #1;
            n++;
            if (took != 0) begin
                acc++;
                bus.in_pixel = 8'($urandom_range(0, 255));
            end
        end
        bus.in_valid = 1'b0;
        chk("t3_total", W'(acc), W'(24));
        repeat (12) @(posedge clk);
        #1;

        // test 5: reset mid-row discards the partial row
        bus.in_sign_mask = 8'h5A;
        for (int i = 0; i < 5; i++) send_px(8'($urandom_range(0, 255)));
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #6 rst = 1'b0;
        chk("t5_out_valid", W'(bus.out_valid), W'(0));
        chk("t5_in_ready", W'(bus.in_ready), W'(1));
        chk("t5_row_cleared", obs_row(), W'(0));
        @(posedge clk);
        #1;
        bus.in_sign_mask = 8'h81;
        for (int i = 0; i < 8; i++) send_px(8'($urandom_range(0, 255)));
        bus.in_valid = 1'b0;
        chk("t5_latency", W'(bus.out_valid), W'(1));
        repeat (4) @(posedge clk);
        #1;

        // test 4: 64 back-to-back pixels with a free consumer
        stalls = 0; pops = 0; bad_gap = 0; last_pop = -1;
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 66; cyc++) begin
            bus.in_valid = (cyc < 64);
            if (cyc % 8 == 0) bus.in_sign_mask = 8'($urandom_range(0, 255));
            bus.in_approx = 1'($urandom_range(0, 1));
            bus.in_pixel  = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (cyc < 64 && !bus.in_ready) stalls++;
            if (bus.out_valid) begin
                if (last_pop >= 0 && cyc - last_pop != 8) bad_gap++;
                last_pop = cyc;
                pops++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("t4_stalls", W'(stalls), W'(0));
        chk("t4_rows", W'(pops), W'(8));
        chk("t4_spacing", W'(bad_gap), W'(0));
        repeat (4) @(posedge clk);
        #1;

`ifdef DCT_STAGER_FLUSH_EN
        // test 6: flush pads a 3-pixel row
        bus.in_sign_mask = 8'h04;
        bus.in_approx    = 1'b0;
        send_px(8'd129);
        send_px(8'd130);
        bus.in_flush = 1'b1;
        send_px(8'd127);
        bus.in_flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("t6_ready_flush", W'(bus.in_ready), W'(0));
        wait_valid(10);
        chk("t6_row", obs_row(),
            {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 1'b0});
        repeat (4) @(posedge clk);
        #1;
`endif

        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
